// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrate, issue, capture, hand back.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 first).
module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_condition,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_condition
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_next;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              owner_q;
  logic              last_grant;
  logic              any_valid;
  logic              winner;
  logic              accept;

  // With no requester valid the winner is irrelevant; holding last_grant keeps it defined.
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) winner = ~last_grant;
    else if (req0_valid)          winner = 1'b0;
    else if (req1_valid)          winner = 1'b1;
    else                          winner = last_grant;
`else
    if (req0_valid)      winner = 1'b0;
    else if (req1_valid) winner = 1'b1;
    else                 winner = last_grant;
`endif
  end

  assign accept     = (state == IDLE) && any_valid;
  assign req0_ready = accept && !winner;
  assign req1_ready = accept && winner;

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      owner_q       <= 1'b0;
      last_grant    <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_condition <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= winner ? req1_op : req0_op;
            a_q        <= winner ? req1_a  : req0_a;
            b_q        <= winner ? req1_b  : req0_b;
            owner_q    <= winner;
            last_grant <= winner;
          end
        end
        EXEC: begin
          rsp_result    <= alu_result;
          rsp_condition <= alu_condition;
          rsp_id        <= owner_q;
          rsp_valid     <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed issues push expected responses, a monitor pops on handshake.
// Expected grant order follows ALU_ARB_RR_EN exactly as the DUT build does.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [DW-1:0] alu_result, rsp_result;
  logic          alu_condition, rsp_valid, rsp_ready, rsp_id, rsp_condition;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] res;
    logic          cond;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_condition(alu_condition),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_condition(rsp_condition)
  );

  // Shared ALU stand-in: add, sub, and, or; condition flags a zero result.
  always_comb begin
    case (alu_op)
      6'b100001: alu_result = alu_a + alu_b;
      6'b100010: alu_result = alu_a - alu_b;
      6'b100100: alu_result = alu_a & alu_b;
      6'b100101: alu_result = alu_a | alu_b;
      default:   alu_result = '0;
    endcase
    alu_condition = (alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        check("rsp_spurious", 64'(rsp_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_result", 64'(rsp_result), 64'(e.res));
        check("rsp_condition", 64'(rsp_condition), 64'(e.cond));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge (DUT in EXEC).
  task automatic issue(input logic id, input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic push,
                       input logic [DW-1:0] er, input logic ec);
    exp_t e;
    if (!id) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    check("grant", 64'(id ? req1_ready : req0_ready), 64'd1);
    check("grant_other", 64'(id ? req0_ready : req1_ready), 64'd0);
    if (push) begin
      e = '{id: id, res: er, cond: ec};
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    check("sb_drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] ids;
    int acc, last, cyc;
    exp_t e;

    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;

    // Reset values while held in reset
    @(negedge clk); #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_condition", 64'(rsp_condition), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle_ready0", 64'(req0_ready), 64'd0);
    check("idle_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);

    // Single add from requester 0
    issue(1'b0, 6'b100001, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0);
    check("t1_exec_valid", 64'(rsp_valid), 64'd0);
    check("t1_exec_ready0", 64'(req0_ready), 64'd0);
    @(negedge clk);
    check("t1_resp_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    check("t1_back_idle", 64'(rsp_valid), 64'd0);
    drain();

    // Both requesters valid continuously for three operations
    pulse_reset();
`ifdef ALU_ARB_RR_EN
    ids = 3'b010;
`else
    ids = 3'b000;
`endif
    req0_op = 6'b100001; req0_a = 32'd1; req0_b = 32'd2;
    req1_op = 6'b100101; req1_a = 32'd8; req1_b = 32'd4;
    for (int k = 0; k < 3; k++) begin
      e = '{id: ids[k], res: (ids[k] ? 32'd12 : 32'd3), cond: 1'b0};
      sbq.push_back(e);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    acc = 0; last = 0; cyc = 0;
    while (acc < 3 && cyc < 60) begin
      #1;
      if (req0_ready || req1_ready) begin
        if (acc > 0) check("t2_issue_interval", 64'(cyc - last), 64'd3);
        last = cyc;
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_accepts", 64'(acc), 64'd3);
    drain();

    // Response backpressure for four cycles
    issue(1'b0, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 32'h0000_F000, 1'b0);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 6'b100001; req1_a = 32'd1; req1_b = 32'd1;
    #1;
    check("t3_exec_ready1", 64'(req1_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("t3_hold_valid", 64'(rsp_valid), 64'd1);
      check("t3_hold_result", 64'(rsp_result), 64'h0000_F000);
      check("t3_hold_id", 64'(rsp_id), 64'd0);
      check("t3_hold_ready0", 64'(req0_ready), 64'd0);
      check("t3_hold_ready1", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("t3_released", 64'(rsp_valid), 64'd0);
    drain();

    // Operands sampled only at the accept edge
    @(negedge clk);
    issue(1'b1, 6'b100001, 32'd100, 32'd23, 1'b1, 32'd123, 1'b0);
    req1_a = 32'd999; req1_b = 32'd1;
    #1;
    check("t4_alu_a", 64'(alu_a), 64'd100);
    check("t4_alu_b", 64'(alu_b), 64'd23);
    drain();

    // Reset during EXEC discards the operation
    @(negedge clk);
    issue(1'b0, 6'b100001, 32'd40, 32'd2, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(rsp_valid), 64'd0);
    check("t5_rst_alu_op", 64'(alu_op), 64'd0);
    check("t5_rst_alu_a", 64'(alu_a), 64'd0);
    check("t5_rst_alu_b", 64'(alu_b), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t5_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req0_op = 6'b100010; req0_a = 32'd9; req0_b = 32'd9;
    req1_op = 6'b100101; req1_a = 32'd1; req1_b = 32'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_grant0", 64'(req0_ready), 64'd1);
    check("t5_grant1", 64'(req1_ready), 64'd0);
    e = '{id: 1'b0, res: 32'd0, cond: 1'b1};
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
